lbp_code_encoder: RTL and testbench

Consumes the eight interpolated neighbour samples (8.16 unsigned fixed point) and the matching centre pixel, and produces one 8-bit LBP code per pixel. Sits directly downstream of the radius-R interpolation stage, on the receiving end of its `done`/`progress_done` sample interface. A small FIFO presents codes to the histogram/output stage over a valid/ready handshake.

---
 rtl/lbp_code_encoder.sv | 133 +++++++++++++
 tb/tb_lbp_code_encoder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_code_encoder.sv
// LBP code encoder: 24-bit neighbour compare, optional rotation-invariant mapping
// (macro LBP_ROT_INV_EN), show-ahead output FIFO and per-frame transfer counters.
module lbp_code_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_i,
  input  logic             progress_done_i,
  input  logic [7:0]       center_i,
  input  logic [23:0]      S1_i,
  input  logic [23:0]      S2_i,
  input  logic [23:0]      S3_i,
  input  logic [23:0]      S4_i,
  input  logic [23:0]      S5_i,
  input  logic [23:0]      S6_i,
  input  logic [23:0]      S7_i,
  input  logic [23:0]      S8_i,
  input  logic             ready_i,
  output logic [7:0]       code_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] code_count_o,
  output logic [CNT_W-1:0] frame_len_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [23:0] center_ext;
  logic [7:0]  cmp_bits;
  logic [7:0]  mapped;

  logic       s1_valid, s1_last;
  logic [7:0] s1_code;
  logic       s2_valid, s2_last;
  logic [7:0] s2_code;

  logic [AW:0] wr_ptr, rd_ptr;
  logic [8:0]  mem [FIFO_DEPTH];
  logic [8:0]  head;
  logic        empty, full, push, pop;

  logic [CNT_W-1:0] count_inc;

  // Centre promoted to 8.16 so the compare is a plain unsigned 24-bit one.
  assign center_ext = {center_i, 16'h0};
  assign cmp_bits = {S8_i >= center_ext, S7_i >= center_ext, S6_i >= center_ext,
                     S5_i >= center_ext, S4_i >= center_ext, S3_i >= center_ext,
                     S2_i >= center_ext, S1_i >= center_ext};

`ifdef LBP_ROT_INV_EN
  function automatic logic [7:0] rot_min(input logic [7:0] c);
    logic [7:0] best, cand;
    best = c;
    for (int r = 1; r < 8; r++) begin
      cand = (c >> r) | (c << (8 - r));
      if (cand < best) best = cand;
    end
    return best;
  endfunction

  assign mapped = rot_min(s1_code);
`else
  assign mapped = s1_code;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_code  <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_code  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage register samples the
      // previous stage's value from before this edge.
      s1_valid <= done_i;
      s1_last  <= done_i & progress_done_i;
      s1_code  <= cmp_bits;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_code  <= mapped;
    end
  end

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid_o = !empty;
  assign pop     = valid_o & ready_i;
  assign push    = s2_valid & (!full | pop);

  assign head   = mem[rd_ptr[AW-1:0]];
  assign code_o = valid_o ? head[8:1] : 8'h00;
  assign last_o = valid_o & head[0];

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are live, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s2_code, s2_last};
  end

  assign count_inc = (code_count_o == CNT_MAX) ? CNT_MAX : code_count_o + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow_o   <= 1'b0;
      code_count_o <= '0;
      frame_len_o  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (s2_valid && full && !pop) overflow_o <= 1'b1;
      if (pop) begin
        if (last_o) begin
          frame_len_o  <= count_inc;
          code_count_o <= '0;
        end else begin
          code_count_o <= count_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_lbp_code_encoder.sv
// Self-checking bench for lbp_code_encoder: queue-based reference model compared
// every cycle, directed literal cases, then randomized traffic.
module tb_lbp_code_encoder;

  localparam int DEPTH = 4;
  localparam int CW    = 20;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          done_i;
  logic          progress_done_i;
  logic [7:0]    center_i;
  logic [23:0]   s_in [8];
  logic          ready_i;
  logic [7:0]    code_o;
  logic          valid_o;
  logic          last_o;
  logic          overflow_o;
  logic [CW-1:0] code_count_o;
  logic [CW-1:0] frame_len_o;

  lbp_code_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .progress_done_i(progress_done_i),
    .center_i(center_i),
    .S1_i(s_in[0]), .S2_i(s_in[1]), .S3_i(s_in[2]), .S4_i(s_in[3]),
    .S5_i(s_in[4]), .S6_i(s_in[5]), .S7_i(s_in[6]), .S8_i(s_in[7]),
    .ready_i(ready_i), .code_o(code_o), .valid_o(valid_o), .last_o(last_o),
    .overflow_o(overflow_o), .code_count_o(code_count_o), .frame_len_o(frame_len_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference: code straight from the comparison rule, rotation minimum via a
  // doubled byte (c*257) shifted right, which yields every circular rotation.
  function automatic logic [7:0] expect_code();
    int unsigned thr, code, x, best;
    thr  = int'(center_i) * 65536;
    code = 0;
    for (int k = 0; k < 8; k++)
      if (int'(s_in[k]) >= thr) code += (1 << k);
`ifdef LBP_ROT_INV_EN
    x    = code * 257;
    best = code;
    for (int r = 1; r < 8; r++)
      if (((x >> r) & 255) < best) best = (x >> r) & 255;
    code = best;
`else
    x    = 0;
    best = 0;
`endif
    return code[7:0];
  endfunction

  typedef struct packed {
    logic       v;
    logic [7:0] c;
    logic       l;
  } ent_t;

  ent_t        p1, p2, e;
  ent_t        q [$];
  logic        m_ovf;
  int unsigned m_cnt, m_flen;
  bit          started = 0;
  bit          m_pop, m_full;

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      p1 = '0;
      p2 = '0;
      m_ovf = 1'b0;
      m_cnt = 0;
      m_flen = 0;
      started = 1;
    end else if (started) begin
      m_pop  = (q.size() != 0) && ready_i;
      m_full = (q.size() == DEPTH);
      if (m_pop) begin
        e = q.pop_front();
        if (e.l) begin
          m_flen = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
          m_cnt  = 0;
        end else begin
          m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        end
      end
      if (p2.v) begin
        if (m_full && !m_pop) m_ovf = 1'b1;
        else q.push_back(p2);
      end
      p2 = p1;
      p1.v = done_i;
      p1.l = done_i && progress_done_i;
      p1.c = expect_code();
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("valid", {31'b0, valid_o}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        check("code", {24'b0, code_o}, {24'b0, q[0].c});
        check("last", {31'b0, last_o}, {31'b0, q[0].l});
      end
      check("overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
      check("code_count", 32'(code_count_o), m_cnt);
      check("frame_len", 32'(frame_len_o), m_flen);
    end
  end

  task automatic set_pix(input logic [7:0] c, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] d, input logic [23:0] rest);
    center_i = c;
    s_in[0] = a;
    s_in[1] = b;
    s_in[2] = d;
    for (int k = 3; k < 8; k++) s_in[k] = rest;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    done_i = 1'b0;
    progress_done_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One pixel with ready high; its code is inspected when it reaches the head.
  task automatic lit_pixel(input string name, input logic [7:0] c, input logic [23:0] a,
                           input logic [23:0] b, input logic [23:0] d, input logic [23:0] rest,
                           input logic [7:0] exp);
    @(negedge clk);
    ready_i = 1'b1;
    done_i = 1'b1;
    set_pix(c, a, b, d, rest);
    @(negedge clk);
    done_i = 1'b0;
    repeat (2) @(negedge clk);
    check({name, "_valid"}, {31'b0, valid_o}, 32'd1);
    check(name, {24'b0, code_o}, {24'b0, exp});
  endtask

  function automatic logic [23:0] rand_nb(input logic [7:0] c);
    logic [23:0] t;
    t = {c, 16'h0};
    case ($urandom_range(0, 3))
      0: return t;
      1: return t - 24'd1;
      2: return t + 24'd1;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    done_i = 1'b1;
    progress_done_i = 1'b0;
    ready_i = 1'b1;
    set_pix(8'd100, 24'h640000, 24'h63FFFF, 24'h650000, 24'h0);

    // Reset held two cycles with done_i high: everything must read zero.
    repeat (2) begin
      @(negedge clk);
      check("rst_valid", {31'b0, valid_o}, 32'd0);
      check("rst_code", {24'b0, code_o}, 32'd0);
      check("rst_last", {31'b0, last_o}, 32'd0);
      check("rst_ovf", {31'b0, overflow_o}, 32'd0);
      check("rst_cnt", 32'(code_count_o), 32'd0);
      check("rst_flen", 32'(frame_len_o), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("lat_e0", {31'b0, valid_o}, 32'd0);
    @(negedge clk);
    check("lat_e1", {31'b0, valid_o}, 32'd0);
    @(negedge clk);
    check("lat_e2", {31'b0, valid_o}, 32'd1);
    done_i = 1'b0;
    repeat (4) @(negedge clk);

    // Compare order, equality and rotation cases.
    lit_pixel("bits_05", 8'd100, 24'h640000, 24'h63FFFF, 24'h650000, 24'h0, 8'h05);
`ifdef LBP_ROT_INV_EN
    lit_pixel("rot_06", 8'd100, 24'h0, 24'h640000, 24'h700000, 24'h0, 8'h03);
`else
    lit_pixel("rot_06", 8'd100, 24'h0, 24'h640000, 24'h700000, 24'h0, 8'h06);
`endif
    @(negedge clk);
    done_i = 1'b1;
    set_pix(8'd100, 24'h0, 24'h0, 24'h0, 24'h0);
    s_in[7] = 24'hFFFFFF;
    @(negedge clk);
    done_i = 1'b0;
    repeat (2) @(negedge clk);
`ifdef LBP_ROT_INV_EN
    check("rot_80", {24'b0, code_o}, 32'h01);
`else
    check("rot_80", {24'b0, code_o}, 32'h80);
`endif
    repeat (2) @(negedge clk);

    // Full FIFO with push and pop on the same edge must not overflow.
    do_reset();
    ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      done_i = 1'b1;
      set_pix(8'(k * 40), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    end
    @(negedge clk);
    done_i = 1'b0;
    ready_i = 1'b1;
    repeat (8) @(negedge clk);
    check("full_pushpop_ovf", {31'b0, overflow_o}, 32'd0);

    // Six pixels into a stalled 4-entry FIFO: two dropped, overflow sticky.
    do_reset();
    ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      done_i = 1'b1;
      set_pix(8'(k * 30 + 7), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    end
    @(negedge clk);
    done_i = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_ovf", {31'b0, overflow_o}, 32'd1);
    ready_i = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_drained", {31'b0, valid_o}, 32'd0);
    check("bp_ovf_sticky", {31'b0, overflow_o}, 32'd1);
    check("bp_count", 32'(code_count_o), 32'd4);

    // Ten-pixel frame, with an ignored progress_done_i pulse in between.
    do_reset();
    ready_i = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 5) begin
        done_i = 1'b0;
        progress_done_i = 1'b1;
      end else begin
        done_i = 1'b1;
        progress_done_i = (k == 10);
        set_pix(8'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
      end
    end
    @(negedge clk);
    done_i = 1'b0;
    progress_done_i = 1'b0;
    repeat (6) @(negedge clk);
    check("frame_len10", 32'(frame_len_o), 32'd10);
    check("frame_cnt0", 32'(code_count_o), 32'd0);

    // Reset with three codes waiting: nothing stale may surface afterwards.
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      done_i = 1'b1;
      set_pix(8'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    end
    @(negedge clk);
    done_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_filled", {31'b0, valid_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'b0, valid_o}, 32'd0);
    rst = 1'b1;
    ready_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("mid_no_stale", {31'b0, valid_o}, 32'd0);
    end

    // Randomized traffic with bursts of backpressure and an occasional reset.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) != 0);
      done_i = ($urandom_range(0, 3) != 0);
      progress_done_i = ($urandom_range(0, 11) == 0);
      ready_i = ((i / 40) % 3 == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      center_i = 8'($urandom);
      for (int k = 0; k < 8; k++) s_in[k] = rand_nb(center_i);
    end
    @(negedge clk);
    rst = 1'b1;
    done_i = 1'b0;
    ready_i = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
